cpu_commit_stage: RTL and testbench
===================================

Name: cpu_commit_stage

Overview:
Memory-access (commit) pipeline stage placed directly downstream of the execute stage. Registers the execute results, performs the data-memory load/store over a req/ack handshake, and formats load data. Delivers the final value to the writeback register, and drives the commit-stage forwarding bus and the back-pressure stall.

Parameters:
DATA_W, 32, width of ALU result, store data and memory data
REG_ID_W, 5, destination register id width
TIMEOUT, 16, maximum WAIT cycles without dmem_ack before the access is abandoned (>=2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
ex_valid  in  1  execute stage presents an instruction
ex_alu_result  in  DATA_W  ALU result; memory byte address for mem ops
ex_rb_data  in  DATA_W  store data
ex_reg_dest  in  REG_ID_W  destination register id
ex_reg_write  in  1  instruction writes a register
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_byte  in  1  1 = byte access, 0 = word access
commit_stall  out  1  combinational; execute must hold its outputs
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_addr  out  DATA_W  word-aligned address (low 2 bits forced 0)
dmem_wdata  out  DATA_W  store data
dmem_be  out  4  byte enables
dmem_ack  in  1  request completed; dmem_rdata valid this cycle
dmem_rdata  in  DATA_W  load data
fw_commit_value  out  DATA_W  forwarding value (S.alu_result)
fw_commit_rd  out  REG_ID_W  forwarding destination id
fw_commit_wb  out  1  forwarding entry valid
wb_valid  out  1  writeback entry valid (one-cycle pulse per instruction)
wb_reg_dest  out  REG_ID_W  writeback destination
wb_reg_write  out  1  writeback enable
wb_value  out  DATA_W  writeback value
mem_error  out  1  sticky: misaligned word access or timeout

Behaviour:
- Reset (reset=0, asynchronous): S.valid=0, state=IDLE, timeout counter=0. All wb_* outputs, dmem_req and mem_error are 0.
- Stage register S: loads all ex_* fields at a posedge when commit_stall=0. It holds when commit_stall=1.
- S is a mem op when ex_mem_read or ex_mem_write was set. It is misaligned when it is a word access with alu_result[1:0]!=0.
- Non-mem op in S: wb_* loads S at the next edge (wb_value=alu_result, wb_valid=1). Latency is 1 cycle from S, 2 cycles from the ex inputs.
- Misaligned mem op: no memory access and no stall. mem_error is set at the next edge. wb_valid=0 for that slot; the op is dropped.
- FSM IDLE: an aligned mem op in S moves the FSM to WAIT at the next edge. commit_stall=1 in that IDLE cycle.
- FSM WAIT: dmem_req=1, with dmem_addr, dmem_we, dmem_be and dmem_wdata driven from S. The counter increments each cycle that dmem_ack=0.
  - dmem_ack=1: commit_stall=0 that cycle. At the edge, wb_* loads and state goes to IDLE. S may accept the next instruction on the same edge.
  - Load result, word access: wb_value=dmem_rdata.
  - Load result, byte access: wb_value is the byte selected by addr[1:0] (0 selects bits 7:0), zero-extended.
  - Store result: wb_valid=1, wb_reg_write=0.
  - Counter reaches TIMEOUT-1 with no ack: mem_error is set, the op is dropped (wb_valid=0), state goes to IDLE, and the stall is released that cycle.
  - A dmem_ack arriving outside WAIT is ignored.
- Byte store: dmem_wdata is the low byte replicated 4x, and dmem_be is one-hot at addr[1:0]. Word store: dmem_be=4'b1111.
- commit_stall = S.valid & aligned mem op & ~(state==WAIT & (dmem_ack | timeout_hit)).
- fw_commit_wb = S.valid & reg_write & ~mem_read. Loads are never forwarded from this stage; the hazard unit covers them.
- wb_valid=0 on any edge where S does not retire.
- mem_error clears only on reset.
- A reset asserted while in WAIT aborts the access immediately (dmem_req drops asynchronously).

Decomposition:
- Shared CPU package gets:
  - the state enum {IDLE, WAIT};
  - the byte-enable/lane-select helper function;
  - an ex-to-commit payload struct (valid, alu_result, rb_data, reg_dest, reg_write, mem_read, mem_write, mem_byte).
- Natural sub-module: cpu_load_align, a combinational byte select/zero-extend and store-lane replication. Everything else stays flat.

Test Plan:
- ALU op: ex_alu_result=0x1234, reg_dest=3, reg_write=1 -> fw_commit_value=0x1234 with fw_commit_wb=1 for one cycle; next cycle wb_valid=1, wb_value=0x1234, wb_reg_dest=3; commit_stall never 1.
- Word load: addr 0x40, ack after 3 WAIT cycles with rdata=0xDEADBEEF -> dmem_addr=0x40, commit_stall high 4 cycles, then wb_value=0xDEADBEEF and fw_commit_wb=0.
- Byte load: addr 0x43, rdata=0xAABBCCDD -> wb_value=0x000000AA.
- Byte store: addr 0x41, rb_data=0x5A -> dmem_be=4'b0010, dmem_wdata=0x5A5A5A5A, dmem_we=1; then wb_valid=1, wb_reg_write=0.
- Error paths:
  - Misaligned word load at 0x42 -> no dmem_req, mem_error=1, no wb_valid.
  - Aligned load with ack held 0 -> dmem_req drops after 16 cycles, mem_error=1.
- Back-to-back load then ALU op, plus a reset pulse asserted mid-WAIT -> ALU op retires on the cycle after the ack edge; after the reset, dmem_req, wb_valid and mem_error are 0 and state is IDLE.

Source files
------------

// File: rtl/cpu_commit_stage_pkg.sv
// Types and helpers shared by the commit (memory-access) stage and its datapath helpers.
package cpu_commit_stage_pkg;

    localparam int CPU_DATA_W   = 32;
    localparam int CPU_REG_ID_W = 5;

    typedef enum logic {
        IDLE,
        WAIT
    } commit_state_t;

    typedef struct packed {
        logic                    valid;
        logic [CPU_DATA_W-1:0]   alu_result;
        logic [CPU_DATA_W-1:0]   rb_data;
        logic [CPU_REG_ID_W-1:0] reg_dest;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_byte;
    } commit_payload_t;

    // One-hot lane for byte accesses, all lanes for word accesses.
    function automatic logic [3:0] byte_lanes(input logic [1:0] lane, input logic is_byte);
        return is_byte ? (4'b0001 << lane) : 4'b1111;
    endfunction

endpackage

// File: rtl/cpu_load_align.sv
// Load-data byte select with zero extension, and store-data lane replication.
module cpu_load_align #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        lane,
    input  logic              is_byte,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_value,
    output logic [DATA_W-1:0] store_wdata
);

    logic [7:0] load_byte;

    always_comb begin
        load_byte   = rdata[{lane, 3'b000} +: 8];
        load_value  = is_byte ? {{(DATA_W-8){1'b0}}, load_byte} : rdata;
        store_wdata = is_byte ? {(DATA_W/8){store_data[7:0]}} : store_data;
    end

endmodule

// File: rtl/cpu_commit_stage.sv
// Commit stage: registers execute results, runs the data-memory req/ack access,
// and delivers the retired value to writeback and the forwarding bus.
module cpu_commit_stage
    import cpu_commit_stage_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int REG_ID_W = CPU_REG_ID_W,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [DATA_W-1:0]   ex_alu_result,
    input  logic [DATA_W-1:0]   ex_rb_data,
    input  logic [REG_ID_W-1:0] ex_reg_dest,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic                ex_mem_byte,
    output logic                commit_stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [3:0]          dmem_be,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic [DATA_W-1:0]   fw_commit_value,
    output logic [REG_ID_W-1:0] fw_commit_rd,
    output logic                fw_commit_wb,
    output logic                wb_valid,
    output logic [REG_ID_W-1:0] wb_reg_dest,
    output logic                wb_reg_write,
    output logic [DATA_W-1:0]   wb_value,
    output logic                mem_error
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    commit_payload_t  ex_pl;
    commit_payload_t  s_p0;
    commit_state_t    state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             s_mem;
    logic             s_misaligned;
    logic             s_mem_go;
    logic             in_wait;
    logic             timeout_hit;
    logic             mem_done;
    logic [DATA_W-1:0] load_value;

    assign ex_pl = '{valid: ex_valid, alu_result: ex_alu_result, rb_data: ex_rb_data,
                     reg_dest: ex_reg_dest, reg_write: ex_reg_write, mem_read: ex_mem_read,
                     mem_write: ex_mem_write, mem_byte: ex_mem_byte};

    assign s_mem        = s_p0.mem_read | s_p0.mem_write;
    assign s_misaligned = s_mem & ~s_p0.mem_byte & (s_p0.alu_result[1:0] != 2'b00);
    assign s_mem_go     = s_p0.valid & s_mem & ~s_misaligned;
    assign in_wait      = (state == WAIT);
    assign timeout_hit  = in_wait & ~dmem_ack & (tmo_cnt == CNT_LAST);
    assign mem_done     = in_wait & (dmem_ack | timeout_hit);
    assign commit_stall = s_mem_go & ~mem_done;

    assign dmem_req  = in_wait;
    assign dmem_we   = s_p0.mem_write;
    assign dmem_addr = {s_p0.alu_result[DATA_W-1:2], 2'b00};
    assign dmem_be   = byte_lanes(s_p0.alu_result[1:0], s_p0.mem_byte);

    // Loads are left to the hazard unit, so only non-load writers forward here.
    assign fw_commit_value = s_p0.alu_result;
    assign fw_commit_rd    = s_p0.reg_dest;
    assign fw_commit_wb    = s_p0.valid & s_p0.reg_write & ~s_p0.mem_read;

    cpu_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata       (dmem_rdata),
        .lane        (s_p0.alu_result[1:0]),
        .is_byte     (s_p0.mem_byte),
        .store_data  (s_p0.rb_data),
        .load_value  (load_value),
        .store_wdata (dmem_wdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s_p0         <= '0;
            state        <= IDLE;
            tmo_cnt      <= '0;
            wb_valid     <= 1'b0;
            wb_reg_dest  <= '0;
            wb_reg_write <= 1'b0;
            wb_value     <= '0;
            mem_error    <= 1'b0;
        end else begin
            // S -> writeback: retire whatever leaves the stage register this edge
            wb_valid <= 1'b0;
            if (s_p0.valid && !commit_stall) begin
                if (!s_mem) begin
                    wb_valid     <= 1'b1;
                    wb_reg_dest  <= s_p0.reg_dest;
                    wb_reg_write <= s_p0.reg_write;
                    wb_value     <= s_p0.alu_result;
                end else if (s_misaligned || timeout_hit) begin
                    mem_error <= 1'b1;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_reg_dest  <= s_p0.reg_dest;
                    wb_reg_write <= s_p0.reg_write & ~s_p0.mem_write;
                    wb_value     <= s_p0.mem_read ? load_value : s_p0.alu_result;
                end
            end

            // ex -> S
            if (!commit_stall) begin
                s_p0 <= ex_pl;
            end

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (s_mem_go) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state   <= IDLE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_commit_stage.sv
// Randomized bench for cpu_commit_stage against a transaction-level model of the stage.
module tb_cpu_commit_stage;

    localparam int DATA_W   = 32;
    localparam int REG_ID_W = 5;
    localparam int TIMEOUT  = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic                ex_valid;
    logic [DATA_W-1:0]   ex_alu_result;
    logic [DATA_W-1:0]   ex_rb_data;
    logic [REG_ID_W-1:0] ex_reg_dest;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic                ex_mem_byte;
    logic                commit_stall;
    logic                dmem_req;
    logic                dmem_we;
    logic [DATA_W-1:0]   dmem_addr;
    logic [DATA_W-1:0]   dmem_wdata;
    logic [3:0]          dmem_be;
    logic                dmem_ack;
    logic [DATA_W-1:0]   dmem_rdata;
    logic [DATA_W-1:0]   fw_commit_value;
    logic [REG_ID_W-1:0] fw_commit_rd;
    logic                fw_commit_wb;
    logic                wb_valid;
    logic [REG_ID_W-1:0] wb_reg_dest;
    logic                wb_reg_write;
    logic [DATA_W-1:0]   wb_value;
    logic                mem_error;

    always #5 clock = ~clock;

    cpu_commit_stage #(.DATA_W(DATA_W), .REG_ID_W(REG_ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clock           (clock),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_alu_result   (ex_alu_result),
        .ex_rb_data      (ex_rb_data),
        .ex_reg_dest     (ex_reg_dest),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_byte     (ex_mem_byte),
        .commit_stall    (commit_stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_be         (dmem_be),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .fw_commit_value (fw_commit_value),
        .fw_commit_rd    (fw_commit_rd),
        .fw_commit_wb    (fw_commit_wb),
        .wb_valid        (wb_valid),
        .wb_reg_dest     (wb_reg_dest),
        .wb_reg_write    (wb_reg_write),
        .wb_value        (wb_value),
        .mem_error       (mem_error)
    );

    // One instruction plus the memory's planned answer to it (ack delay in WAIT cycles, read data).
    typedef struct {
        bit        v;
        bit [31:0] alu;
        bit [31:0] rb;
        bit [4:0]  rd;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        mb;
        int        dly;
        bit [31:0] rdata;
    } op_t;

    int        n_checks = 0;
    int        n_pass   = 0;
    op_t       dq[$];
    op_t       cur;
    op_t       m_s;
    int        m_age;
    bit        m_wbv;
    bit        m_wbrw;
    bit        m_wbval_chk;
    bit [4:0]  m_wbrd;
    bit [31:0] m_wbval;
    bit        m_err;
    bit        rnd;
    bit        rst_arm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic op_t mk_op(input bit v, input bit [31:0] alu, input bit [31:0] rb,
                                  input bit [4:0] rd, input bit rw, input bit mr, input bit mw,
                                  input bit mb, input int dly, input bit [31:0] rdata);
        op_t o;
        o.v = v; o.alu = alu; o.rb = rb; o.rd = rd; o.rw = rw;
        o.mr = mr; o.mw = mw; o.mb = mb; o.dly = dly; o.rdata = rdata;
        return o;
    endfunction

    function automatic bit is_mem(input op_t o);
        return o.mr | o.mw;
    endfunction

    function automatic bit misaligned(input op_t o);
        return is_mem(o) && !o.mb && (o.alu[1:0] != 2'b00);
    endfunction

    function automatic bit goes_to_mem(input op_t o);
        return o.v && is_mem(o) && !misaligned(o);
    endfunction

    function automatic op_t bubble();
        return mk_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0);
    endfunction

    task automatic rand_op(output op_t o);
        int kind;
        kind = $urandom_range(0, 9);
        o = mk_op($urandom_range(0, 5) != 0, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  kind < 3, kind inside {3, 4}, 1'($urandom), $urandom_range(0, 4), $urandom);
        if (is_mem(o) && !o.mb && $urandom_range(0, 7) != 0) o.alu[1:0] = 2'b00;
        if ($urandom_range(0, 11) == 0) o.dly = TIMEOUT + 4;
    endtask

    task automatic next_op(output op_t o);
        if (dq.size() > 0) o = dq.pop_front();
        else if (rnd) rand_op(o);
        else o = bubble();
    endtask

    task automatic drive(input op_t o);
        ex_valid      = o.v;
        ex_alu_result = o.alu;
        ex_rb_data    = o.rb;
        ex_reg_dest   = o.rd;
        ex_reg_write  = o.rw;
        ex_mem_read   = o.mr;
        ex_mem_write  = o.mw;
        ex_mem_byte   = o.mb;
    endtask

    task automatic model_reset();
        m_s = bubble(); m_age = 0; m_wbv = 1'b0; m_wbrw = 1'b0; m_wbval_chk = 1'b0;
        m_wbrd = '0; m_wbval = '0; m_err = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_dmem_req", 32'(dmem_req), 32'(1'b0));
        check("rst_wb_valid", 32'(wb_valid), 32'(1'b0));
        check("rst_wb_reg_write", 32'(wb_reg_write), 32'(1'b0));
        check("rst_wb_reg_dest", 32'(wb_reg_dest), 32'(5'd0));
        check("rst_wb_value", wb_value, 32'h0);
        check("rst_mem_error", 32'(mem_error), 32'(1'b0));
        check("rst_commit_stall", 32'(commit_stall), 32'(1'b0));
    endtask

    // One clock cycle: compare outputs at the negedge, answer the memory, then advance the model.
    task automatic cycle(input bit force_rst);
        bit req, ack, tmo, stall, fwexp, do_rst;
        int k;
        @(negedge clock);
        req = goes_to_mem(m_s) && m_age >= 1;
        k   = m_age - 1;
        check("dmem_req", 32'(dmem_req), 32'(req));
        if (req) begin
            check("dmem_addr", dmem_addr, m_s.alu & 32'hFFFF_FFFC);
            check("dmem_we", 32'(dmem_we), 32'(m_s.mw));
            check("dmem_be", 32'(dmem_be), 32'(m_s.mb ? (4'b0001 << m_s.alu[1:0]) : 4'b1111));
            if (m_s.mw) check("dmem_wdata", dmem_wdata, m_s.mb ? {4{m_s.rb[7:0]}} : m_s.rb);
        end
        check("wb_valid", 32'(wb_valid), 32'(m_wbv));
        if (m_wbv) begin
            check("wb_reg_dest", 32'(wb_reg_dest), 32'(m_wbrd));
            check("wb_reg_write", 32'(wb_reg_write), 32'(m_wbrw));
            if (m_wbval_chk) check("wb_value", wb_value, m_wbval);
        end
        check("mem_error", 32'(mem_error), 32'(m_err));
        fwexp = m_s.v && m_s.rw && !m_s.mr;
        check("fw_commit_wb", 32'(fw_commit_wb), 32'(fwexp));
        if (fwexp) begin
            check("fw_commit_value", fw_commit_value, m_s.alu);
            check("fw_commit_rd", 32'(fw_commit_rd), 32'(m_s.rd));
        end

        if (req) begin
            ack        = (k == m_s.dly);
            dmem_rdata = ack ? m_s.rdata : $urandom;
        end else begin
            ack        = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
        end
        dmem_ack = ack;
        tmo      = req && !ack && (k == TIMEOUT - 1);
        stall    = goes_to_mem(m_s) && !(req && (ack || tmo));
        #1;
        check("commit_stall", 32'(commit_stall), 32'(stall));

        do_rst = force_rst || (rst_arm && req);
        if (do_rst) begin
            rst_arm = 1'b0;
            reset   = 1'b0;
            #1;
            check_reset_outputs();
            @(posedge clock);
            #1;
            reset = 1'b1;
            model_reset();
            next_op(cur);
            drive(cur);
            return;
        end

        @(posedge clock);
        m_wbv = 1'b0;
        if (m_s.v && !stall) begin
            if (!is_mem(m_s)) begin
                m_wbv = 1'b1; m_wbrd = m_s.rd; m_wbrw = m_s.rw; m_wbval = m_s.alu; m_wbval_chk = 1'b1;
            end else if (misaligned(m_s) || tmo) begin
                m_err = 1'b1;
            end else begin
                m_wbv  = 1'b1;
                m_wbrd = m_s.rd;
                m_wbrw = m_s.mr ? m_s.rw : 1'b0;
                m_wbval_chk = m_s.mr;
                if (m_s.mb) m_wbval = (m_s.rdata >> (8 * int'(m_s.alu[1:0]))) & 32'h0000_00FF;
                else m_wbval = m_s.rdata;
            end
        end
        if (!stall) begin
            m_s   = cur;
            m_age = 0;
        end else begin
            m_age++;
        end
        #1;
        if (!stall) begin
            next_op(cur);
            drive(cur);
        end
    endtask

    initial begin
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        rnd        = 1'b0;
        rst_arm    = 1'b0;
        model_reset();
        cur = bubble();
        drive(cur);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clock);
        #1 reset = 1'b1;

        // ALU op, word load (3 idle WAIT cycles), byte load, byte store, load then back-to-back ALU op
        dq.push_back(mk_op(1'b1, 32'h1234, '0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0));
        dq.push_back(bubble());
        dq.push_back(mk_op(1'b1, 32'h40, '0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3, 32'hDEADBEEF));
        dq.push_back(mk_op(1'b1, 32'h43, '0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1, 32'hAABBCCDD));
        dq.push_back(mk_op(1'b1, 32'h41, 32'h5A, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, '0));
        dq.push_back(mk_op(1'b1, 32'h80, '0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2, 32'h600DF00D));
        dq.push_back(mk_op(1'b1, 32'h55, '0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0));
        repeat (30) cycle(1'b0);
        cycle(1'b1);

        // Misaligned word load
        dq.push_back(mk_op(1'b1, 32'h42, '0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 0, '0));
        repeat (5) cycle(1'b0);
        cycle(1'b1);

        // Load that never gets an ack
        dq.push_back(mk_op(1'b1, 32'h100, '0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, TIMEOUT + 10, '0));
        repeat (24) cycle(1'b0);
        cycle(1'b1);

        // Reset while the access is outstanding
        dq.push_back(mk_op(1'b1, 32'h200, '0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, TIMEOUT + 10, '0));
        repeat (6) cycle(1'b0);
        cycle(1'b1);

        rnd = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 59) == 0) rst_arm = 1'b1;
            cycle(1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
